// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: FIFO write/read/status bundle; master = producer/consumer side, slave = FIFO side
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fifo_cnt;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with almost flags, read-valid strobe and sticky error flags
// Ports: clk, rst_n (async active-low), bus (sync_fifo_flags_if.slave: wr/rd requests, data, flags, count, errors).
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read, latency 1.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH-2,
  parameter int AE_LEVEL   = 2
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_flags_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_acc, rd_acc, full, empty;
  // Pointer difference wraps modulo 2**(ADDR_WIDTH+1), so the extra MSB separates full from empty.
  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign full  = cnt == (ADDR_WIDTH+1)'(DEPTH);
  assign empty = cnt == '0;
  always_comb begin
    wr_acc      = bus.wr_en && !full;
    rd_acc      = bus.rd_en && !empty;
    wr_ptr_d    = wr_ptr_q + (ADDR_WIDTH+1)'(wr_acc);
    rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH+1)'(rd_acc);
    overflow_d  = (bus.wr_en && full) || (overflow_q && !bus.err_clr);
    underflow_d = (bus.rd_en && empty) || (underflow_q && !bus.err_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign bus.rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  always_comb begin
    rd_data_d  = rd_acc ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;
    rd_valid_d = rd_acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif
  assign bus.fifo_cnt     = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = cnt >= (ADDR_WIDTH+1)'(AF_LEVEL);
  assign bus.almost_empty = cnt <= (ADDR_WIDTH+1)'(AE_LEVEL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
